imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage of the RV32I/RV64I core. It accepts fetched instructions over a valid/ready handshake, decodes the immediate format from the opcode, and builds the sign- or zero-extended XLEN-bit immediate. Results queue in a small elastic FIFO, so fetch and execute can stall independently without losing or duplicating instructions. Successor to the combinational immediate unit; the legacy 4-bit format code is still produced for downstream muxes.

---
 rtl/imm_gen_pipe_if.sv | 35 +++
 rtl/imm_gen_pipe.sv | 179 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if -- handshake/data bundle for imm_gen_pipe.
//
//   in_valid/in_ready/inst/in_tag  : instruction input (fetch side)
//   out_valid/out_ready            : result handshake (execute side)
//   imm/imm_type/out_inst/out_tag  : head-of-queue result fields
//   illegal                        : head opcode unsupported (0 unless enabled)
//
// master = the environment driving instructions and consuming results,
// slave  = the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [3:0]       imm_type;
    logic [31:0]      out_inst;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, inst, in_tag, out_ready,
        input  in_ready, out_valid, imm, imm_type, out_inst, out_tag, illegal
    );

    modport slave (
        input  in_valid, inst, in_tag, out_ready,
        output in_ready, out_valid, imm, imm_type, out_inst, out_tag, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- registered RV32I/RV64I immediate generator with an
// elastic output FIFO.
//
// Ports:
//   clk    : clock, all state on rising edge
//   rst    : asynchronous active-high reset, discards all entries
//   flush  : synchronous; empties the queue, drops a same-cycle push
//   bus    : imm_gen_pipe_if.slave (instruction in, immediate/result out)
//
// Parameters: XLEN (32 or 64), TAG_W (sideband tag width),
//             DEPTH (FIFO entries, power of two, >= 2).
//
// Optional feature: define IMM_ILLEGAL_EN to store and report a per-entry
// illegal-opcode flag; otherwise bus.illegal is tied 0.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    imm_gen_pipe_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [3:0] T_LUI   = 4'd0;
    localparam logic [3:0] T_AUIPC = 4'd1;
    localparam logic [3:0] T_JAL   = 4'd2;
    localparam logic [3:0] T_JALR  = 4'd3;
    localparam logic [3:0] T_S     = 4'd4;
    localparam logic [3:0] T_LOAD  = 4'd5;
    localparam logic [3:0] T_ALUI  = 4'd6;
    localparam logic [3:0] T_B     = 4'd7;
    localparam logic [3:0] T_NONE  = 4'd8;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [3:0]       typ;
        logic [31:0]      inst;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_EN
        logic             ill;
`endif
    } entry_t;

    // Every format is first assembled as a signed 32-bit value, then
    // widened here; for XLEN=64 bit 31 fills the upper word.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] shamt(input logic [31:0] i);
        logic [XLEN-1:0] r;
        r = '0;
        if (XLEN == 64) r[5:0] = i[25:20];
        else            r[4:0] = i[24:20];
        return r;
    endfunction

    // ---------------- decode ----------------
    entry_t      din;
    logic [31:0] in_i;
    assign in_i = bus.inst;

    always_comb begin
        din      = '0;
        din.inst = in_i;
        din.tag  = bus.in_tag;
        din.typ  = T_NONE;
        case (in_i[6:0])
            OP_LUI: begin
                din.typ = T_LUI;
                din.imm = sext32({in_i[31:12], 12'b0});
            end
            OP_AUIPC: begin
                din.typ = T_AUIPC;
                din.imm = sext32({in_i[31:12], 12'b0});
            end
            OP_JAL: begin
                din.typ = T_JAL;
                din.imm = sext32({{11{in_i[31]}}, in_i[31], in_i[19:12],
                                  in_i[20], in_i[30:21], 1'b0});
            end
            OP_JALR: begin
                din.typ = T_JALR;
                din.imm = sext32({{20{in_i[31]}}, in_i[31:20]});
            end
            OP_LOAD: begin
                din.typ = T_LOAD;
                din.imm = sext32({{20{in_i[31]}}, in_i[31:20]});
            end
            OP_STORE: begin
                din.typ = T_S;
                din.imm = sext32({{20{in_i[31]}}, in_i[31:25], in_i[11:7]});
            end
            OP_BR: begin
                din.typ = T_B;
                din.imm = sext32({{19{in_i[31]}}, in_i[31], in_i[7],
                                  in_i[30:25], in_i[11:8], 1'b0});
            end
            OP_ALUI: begin
                din.typ = T_ALUI;
                // slli/srli/srai carry an unsigned shift amount, not an imm12
                if (in_i[13:12] == 2'b01) din.imm = shamt(in_i);
                else                      din.imm = sext32({{20{in_i[31]}}, in_i[31:20]});
            end
            default: begin
                din.typ = T_NONE;
                din.imm = '0;
            end
        endcase
`ifdef IMM_ILLEGAL_EN
        din.ill = (din.typ == T_NONE) || (in_i[1:0] != 2'b11);
`endif
    end

    // ---------------- FIFO ----------------
    logic [PW:0] wr_ptr, rd_ptr, count;
    entry_t      mem [DEPTH];
    entry_t      head;
    logic        push, pop, not_empty;

    assign not_empty    = (count != '0);
    // Ready comes from registered count only: no comb path from out_ready.
    assign bus.in_ready = (count != (PW+1)'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready && !flush;
    assign pop          = not_empty && bus.out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign head = not_empty ? mem[rd_ptr[PW-1:0]] : '0;

    assign bus.out_valid = not_empty;
    assign bus.imm       = head.imm;
    assign bus.imm_type  = head.typ;
    assign bus.out_inst  = head.inst;
    assign bus.out_tag   = head.tag;
`ifdef IMM_ILLEGAL_EN
    assign bus.illegal   = head.ill;
`else
    assign bus.illegal   = 1'b0;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe -- table-driven check of imm_gen_pipe (XLEN=32, DEPTH=2)
// with a scoreboard queue, plus a second XLEN=64 instance for the wide cases.
module tb_imm_gen_pipe;
`ifdef IMM_ILLEGAL_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(b));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64));

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [3:0]  typ;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] tag;
        logic [31:0] imm;
        logic [3:0]  typ;
        logic        ill;
    } exp_t;

    localparam int NV = 14;
    vec_t  tbl [NV];
    exp_t  sb [$];
    vec_t  cur_v;
    logic [31:0] cur_tag;
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_pop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [31:0] tag);
        b.in_valid = 1'b1;
        b.inst     = v.inst;
        b.in_tag   = tag;
        cur_v      = v;
        cur_tag    = tag;
    endtask

    // Record what the coming edge does, compare any pop, then advance.
    task automatic tick();
        logic acc, pp;
        exp_t e;
        acc = b.in_valid && b.in_ready && !flush;
        pp  = b.out_valid && b.out_ready && !flush;
        if (flush) sb.delete();
        else begin
            if (pp) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_out: got inst %0h expected nothing", b.out_inst);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    chk("imm",      64'(b.imm),      64'(e.imm));
                    chk("imm_type", 64'(b.imm_type), 64'(e.typ));
                    chk("out_inst", 64'(b.out_inst), 64'(e.inst));
                    chk("out_tag",  64'(b.out_tag),  64'(e.tag));
                    chk("illegal",  64'(b.illegal),  64'(e.ill));
                end
            end
            if (acc) sb.push_back('{cur_v.inst, cur_tag, cur_v.imm, cur_v.typ, cur_v.ill});
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(b.out_valid), 64'd0);
    endtask

    function automatic logic [31:0] tg(input int i);
        return 32'h1000 + 32'(i) * 4;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 4'd6, 1'b0}; // addi -1
        tbl[1]  = '{32'h800000EF, 32'hFFF00000, 4'd2, 1'b0}; // jal
        tbl[2]  = '{32'h00001337, 32'h00001000, 4'd0, 1'b0}; // lui
        tbl[3]  = '{32'h00509093, 32'h00000005, 4'd6, 1'b0}; // slli 5
        tbl[4]  = '{32'hFE000EE3, 32'hFFFFFFFC, 4'd7, 1'b0}; // beq -4
        tbl[5]  = '{32'h12345017, 32'h12345000, 4'd1, 1'b0}; // auipc
        tbl[6]  = '{32'h00C50067, 32'h0000000C, 4'd3, 1'b0}; // jalr 12
        tbl[7]  = '{32'hFFC52283, 32'hFFFFFFFC, 4'd5, 1'b0}; // lw -4
        tbl[8]  = '{32'hFE552C23, 32'hFFFFFFF8, 4'd4, 1'b0}; // sw -8
        tbl[9]  = '{32'h4030D093, 32'h00000003, 4'd6, 1'b0}; // srai 3
        tbl[10] = '{32'h7FF07093, 32'h000007FF, 4'd6, 1'b0}; // andi 0x7ff
        tbl[11] = '{32'h00000000, 32'h00000000, 4'd8, ILL_ON}; // unsupported
        tbl[12] = '{32'h800000B7, 32'h80000000, 4'd0, 1'b0}; // lui msb
        tbl[13] = '{32'h0000007F, 32'h00000000, 4'd8, ILL_ON}; // unsupported

        b.in_valid = 1'b0; b.inst = '0; b.in_tag = '0; b.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.inst = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
        cur_v = tbl[0]; cur_tag = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(b.out_valid), 64'd0);
        chk("rst_in_ready",  64'(b.in_ready),  64'd1);
        chk("rst_imm",       64'(b.imm),       64'd0);
        chk("rst_imm_type",  64'(b.imm_type),  64'd0);
        chk("rst_out_inst",  64'(b.out_inst),  64'd0);
        chk("rst_out_tag",   64'(b.out_tag),   64'd0);
        chk("rst_illegal",   64'(b.illegal),   64'd0);
        rst = 1'b0;
        tick();

        // table stream at full rate
        b.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i], tg(i));
            chk($sformatf("tput_ready_%0d", i), 64'(b.in_ready), 64'd1);
            if (i > 0) chk($sformatf("tput_valid_%0d", i), 64'(b.out_valid), 64'd1);
            tick();
        end
        drain();

        // backpressure: third instruction must wait for a pop
        p0 = n_pop;
        b.out_ready = 1'b0;
        drive(tbl[0], tg(20)); tick();
        chk("bp_ready_1", 64'(b.in_ready), 64'd1);
        drive(tbl[1], tg(21)); tick();
        chk("bp_ready_fall", 64'(b.in_ready), 64'd0);
        drive(tbl[2], tg(22)); tick(); tick();
        chk("bp_ready_held", 64'(b.in_ready), 64'd0);
        chk("bp_stable_inst", 64'(b.out_inst), 64'(tbl[0].inst));
        chk("bp_stable_tag",  64'(b.out_tag),  64'(tg(20)));
        b.out_ready = 1'b1;
        tick();
        chk("bp_ready_rise", 64'(b.in_ready), 64'd1);
        tick();
        drain();
        chk("bp_no_dup", 64'(n_pop - p0), 64'd3);

        // flush with full FIFO and a concurrent push attempt
        b.out_ready = 1'b0;
        drive(tbl[3], tg(30)); tick();
        drive(tbl[4], tg(31)); tick();
        drive(tbl[5], tg(32)); flush = 1'b1; tick();
        flush = 1'b0; b.in_valid = 1'b0;
        chk("fl_valid", 64'(b.out_valid), 64'd0);
        chk("fl_ready", 64'(b.in_ready),  64'd1);
        // flush with room: the same-cycle push is dropped
        drive(tbl[6], tg(33)); tick();
        drive(tbl[7], tg(34)); flush = 1'b1; tick();
        flush = 1'b0; b.in_valid = 1'b0;
        chk("fl2_valid", 64'(b.out_valid), 64'd0);
        chk("fl2_ready", 64'(b.in_ready),  64'd1);
        b.out_ready = 1'b1;
        tick(); tick();
        chk("fl2_stays_empty", 64'(b.out_valid), 64'd0);

        // asynchronous reset between edges in the middle of a burst
        b.out_ready = 1'b0;
        drive(tbl[8], tg(40)); tick();
        drive(tbl[9], tg(41)); tick();
        drive(tbl[10], tg(42));
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(b.out_valid), 64'd0);
        chk("arst_ready", 64'(b.in_ready),  64'd1);
        chk("arst_imm",   64'(b.imm),       64'd0);
        chk("arst_tag",   64'(b.out_tag),   64'd0);
        sb.delete();
        b.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        drive(tbl[4], tg(43)); tick();
        b.in_valid = 1'b0;
        chk("lat_valid", 64'(b.out_valid), 64'd1);
        chk("lat_inst",  64'(b.out_inst),  64'(tbl[4].inst));
        chk("lat_imm",   64'(b.imm),       64'(tbl[4].imm));
        drain();

        // XLEN=64 instance
        begin
            logic [31:0] i64 [4];
            logic [63:0] e64 [4];
            logic [3:0]  t64 [4];
            logic        l64 [4];
            i64[0] = 32'h4210D093; e64[0] = 64'd33;                 t64[0] = 4'd6; l64[0] = 1'b0;
            i64[1] = 32'h800000B7; e64[1] = 64'hFFFFFFFF80000000;   t64[1] = 4'd0; l64[1] = 1'b0;
            i64[2] = 32'h00000000; e64[2] = 64'd0;                  t64[2] = 4'd8; l64[2] = ILL_ON;
            i64[3] = 32'hFFF00093; e64[3] = 64'hFFFFFFFFFFFFFFFF;   t64[3] = 4'd6; l64[3] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                b64.in_valid = 1'b1; b64.inst = i64[k]; b64.in_tag = tg(50 + k);
                @(posedge clk); #1;
                b64.in_valid = 1'b0;
                chk($sformatf("x64_valid_%0d", k),   64'(b64.out_valid), 64'd1);
                chk($sformatf("x64_imm_%0d", k),     b64.imm,            e64[k]);
                chk($sformatf("x64_type_%0d", k),    64'(b64.imm_type),  64'(t64[k]));
                chk($sformatf("x64_illegal_%0d", k), 64'(b64.illegal),   64'(l64[k]));
                chk($sformatf("x64_tag_%0d", k),     64'(b64.out_tag),   64'(tg(50 + k)));
                @(posedge clk); #1;
            end
            chk("x64_empty", 64'(b64.out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
